thermo_bar_driver: RTL and testbench

Parametrised LED bar-graph driver and successor to the fixed 4-bit/10-LED thermometer decoder. It accepts a binary level plus a valid strobe and saturates it to the bar length. The displayed level ramps toward the target one LED per prescaled step tick, giving a visible fill/drain animation. The block sits between counter/measurement logic and the board LED pins, and supports bar or single-dot display modes.

---
 rtl/thermo_bar_driver_pkg.sv | 13 +
 rtl/thermo_decode.sv | 24 ++
 rtl/thermo_bar_driver.sv | 142 ++++++++++++++
 tb/tb_thermo_bar_driver.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/thermo_bar_driver_pkg.sv
// Shared definitions for the LED bar-graph driver: display-mode encodings
// and the width of the displayed-level bus.
package thermo_bar_driver_pkg;

    localparam logic MODE_BAR = 1'b0;  // thermometer fill
    localparam logic MODE_DOT = 1'b1;  // single lit LED

    // Width needed to hold a level in 0..n_leds inclusive.
    function automatic int lvl_width(input int n_leds);
        return $clog2(n_leds + 1);
    endfunction

endpackage

// File: rtl/thermo_decode.sv
// Combinational level-to-LED decoder. Bar mode lights every LED below the
// level; dot mode lights only the LED at position level-1. Level 0 is dark.
module thermo_decode
    import thermo_bar_driver_pkg::*;
#(
    parameter int N_LEDS = 10,
    parameter int LVL_W  = lvl_width(N_LEDS)
) (
    input  logic [LVL_W-1:0]  level,
    input  logic              mode,
    output logic [N_LEDS-1:0] leds
);

    // Per-LED compare against the level; pure combinational decode.
    always_comb begin
        // NOTE: default every combinational output first so no path leaves it unassigned (avoids latches).
        leds = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            if (mode == MODE_DOT) leds[i] = (int'(level) == i + 1);
            else                  leds[i] = (i < int'(level));
        end
    end

endmodule

// File: rtl/thermo_bar_driver.sv
// LED bar-graph driver. Latches a saturated target level on value_valid and
// ramps the displayed level toward it by one LED per prescaled step tick.
// The LED pattern is registered one clock after level/mode.
// Optional feature: define PEAK_HOLD_EN to add a held, slowly decaying
// peak-indicator LED on top of the bar or dot.
module thermo_bar_driver
    import thermo_bar_driver_pkg::*;
#(
    parameter int  N_LEDS          = 10,
    parameter int  VAL_W           = 4,
    parameter int  STEP_DIV        = 5000000,
    parameter int  PEAK_HOLD_STEPS = 20,
    localparam int LVL_W           = lvl_width(N_LEDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [VAL_W-1:0]  value,
    input  logic              value_valid,
    input  logic              mode,
    output logic [N_LEDS-1:0] leds,
    output logic [LVL_W-1:0]  level,
    output logic              busy
);

    localparam int              PW       = $clog2(STEP_DIV);
    localparam logic [PW-1:0]   DIV_LAST = PW'(STEP_DIV - 1);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(N_LEDS);

    // Reject configurations the ramp and prescaler cannot support.
    if (N_LEDS < 2 || STEP_DIV < 2 || PEAK_HOLD_STEPS < 1) begin : g_bad_params
        $error("thermo_bar_driver: N_LEDS and STEP_DIV must be >= 2, PEAK_HOLD_STEPS >= 1");
    end

    logic [PW-1:0]     cnt_q, cnt_d;
    logic              step_tick;
    logic [LVL_W-1:0]  target_q, target_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [N_LEDS-1:0] leds_q, leds_d;
    logic [N_LEDS-1:0] level_vec;

    assign step_tick = (cnt_q == DIV_LAST);

    // Free-running prescaler, wraps after the tick cycle.
    always_comb begin
        cnt_d = step_tick ? '0 : cnt_q + 1'b1;
    end

    // Target capture with saturation to the bar length.
    always_comb begin
        target_d = target_q;
        if (value_valid) begin
            if (int'(value) > N_LEDS) target_d = LVL_MAX;
            else                      target_d = LVL_W'(value);
        end
    end

    // One-LED-per-tick ramp toward the target held before this edge.
    always_comb begin
        level_d = level_q;
        if (step_tick) begin
            if (level_q < target_q)      level_d = level_q + 1'b1;
            else if (level_q > target_q) level_d = level_q - 1'b1;
        end
    end

    thermo_decode #(.N_LEDS(N_LEDS), .LVL_W(LVL_W)) u_level_decode (
        .level (level_q),
        .mode  (mode),
        .leds  (level_vec)
    );

`ifdef PEAK_HOLD_EN
    localparam int                HOLD_W    = $clog2(PEAK_HOLD_STEPS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(PEAK_HOLD_STEPS);

    logic [LVL_W-1:0]  peak_q, peak_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [N_LEDS-1:0] peak_vec;

    // Peak tracking: capture new maxima, hold, then decay toward the level.
    always_comb begin
        peak_d = peak_q;
        hold_d = hold_q;
        if (level_q > peak_q) begin
            peak_d = level_q;
            hold_d = HOLD_LOAD;
        end else if (step_tick) begin
            if (hold_q != '0)         hold_d = hold_q - 1'b1;
            else if (peak_q > level_q) peak_d = peak_q - 1'b1;
        end
    end

    // The peak indicator is always a single LED, whatever the display mode.
    thermo_decode #(.N_LEDS(N_LEDS), .LVL_W(LVL_W)) u_peak_decode (
        .level (peak_q),
        .mode  (MODE_DOT),
        .leds  (peak_vec)
    );

    // Peak state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
            hold_q <= '0;
        end else begin
            peak_q <= peak_d;
            hold_q <= hold_d;
        end
    end

    // LED pattern: level decode with the peak LED overlaid.
    always_comb begin
        leds_d = level_vec | peak_vec;
    end
`else
    // LED pattern: level decode only.
    always_comb begin
        leds_d = level_vec;
    end
`endif

    // Prescaler, target, level and registered LED outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            target_q <= '0;
            level_q  <= '0;
            leds_q   <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
            cnt_q    <= cnt_d;
            target_q <= target_d;
            level_q  <= level_d;
            leds_q   <= leds_d;
        end
    end

    assign leds  = leds_q;
    assign level = level_q;
    assign busy  = (level_q != target_q);

endmodule

// File: tb/tb_thermo_bar_driver.sv
// Self-checking bench for thermo_bar_driver. A cycle-level reference model
// built from plain integer arithmetic predicts leds/level/busy every clock;
// directed steps add fixed expected patterns at the key points.
module tb_thermo_bar_driver;

    localparam int N_LEDS   = 10;
    localparam int VAL_W    = 4;
    localparam int STEP_DIV = 4;
    localparam int HOLD     = 2;
    localparam int LVL_W    = $clog2(N_LEDS + 1);

    logic              clk;
    logic              rst_n;
    logic [VAL_W-1:0]  value;
    logic              value_valid;
    logic              mode;
    logic [N_LEDS-1:0] leds;
    logic [LVL_W-1:0]  level;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    int m_cnt, m_tgt, m_lvl, m_leds, m_peak, m_hold;

    thermo_bar_driver #(
        .N_LEDS          (N_LEDS),
        .VAL_W           (VAL_W),
        .STEP_DIV        (STEP_DIV),
        .PEAK_HOLD_STEPS (HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value       (value),
        .value_valid (value_valid),
        .mode        (mode),
        .leds        (leds),
        .level       (level),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_tgt = 0; m_lvl = 0; m_leds = 0; m_peak = 0; m_hold = 0;
    endtask

    // Advance the model by one rising edge using the inputs seen at that edge.
    task automatic model_edge();
        bit tick;
        int pat, n_lvl, n_peak, n_hold;
        tick = (m_cnt == STEP_DIV - 1);
        if (m_lvl == 0)  pat = 0;
        else if (mode)   pat = 1 << (m_lvl - 1);
        else             pat = (1 << m_lvl) - 1;
`ifdef PEAK_HOLD_EN
        if (m_peak > 0) pat = pat | (1 << (m_peak - 1));
`endif
        n_lvl = m_lvl;
        if (tick && m_lvl < m_tgt) n_lvl = m_lvl + 1;
        if (tick && m_lvl > m_tgt) n_lvl = m_lvl - 1;
        n_peak = m_peak;
        n_hold = m_hold;
        if (m_lvl > m_peak) begin
            n_peak = m_lvl;
            n_hold = HOLD;
        end else if (tick) begin
            if (m_hold > 0)          n_hold = m_hold - 1;
            else if (m_peak > m_lvl) n_peak = m_peak - 1;
        end
        if (value_valid) m_tgt = (int'(value) > N_LEDS) ? N_LEDS : int'(value);
        m_cnt  = tick ? 0 : m_cnt + 1;
        m_leds = pat;
        m_lvl  = n_lvl;
        m_peak = n_peak;
        m_hold = n_hold;
    endtask

    // One clock: update the model at the edge, compare outputs 1 ns later.
    task automatic clk_cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("leds",  32'(leds),  32'(m_leds));
        check("level", 32'(level), 32'(m_lvl));
        check("busy",  32'(busy),  32'(m_lvl != m_tgt));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) clk_cycle();
    endtask

    task automatic strobe(input logic [VAL_W-1:0] v);
        value = v;
        value_valid = 1'b1;
        clk_cycle();
        value_valid = 1'b0;
        value = $urandom_range(0, 15);  // ignored while value_valid is low
    endtask

    initial begin
        logic peak_on;
`ifdef PEAK_HOLD_EN
        peak_on = 1'b1;
`else
        peak_on = 1'b0;
`endif
        rst_n = 1'b0; value = '0; value_valid = 1'b0; mode = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1. Idle after reset.
        run(50);
        check("idle_leds",  32'(leds),  32'h0);
        check("idle_level", 32'(level), 32'h0);
        check("idle_busy",  32'(busy),  32'h0);

        // 2. Ramp up to 7.
        strobe(4'd7);
        check("ramp7_busy_start", 32'(busy), 32'h1);
        run(40);
        check("ramp7_leds",  32'(leds),  32'(10'b0001111111));
        check("ramp7_level", 32'(level), 32'd7);
        check("ramp7_busy",  32'(busy),  32'h0);

        // 3. Saturating request.
        strobe(4'd15);
        run(40);
        check("sat_leds",  32'(leds),  32'(10'b1111111111));
        check("sat_level", 32'(level), 32'd10);

        // 4. New target on the tick edge: that tick still uses the old target.
        for (int i = 0; i < 2 * STEP_DIV && m_cnt != STEP_DIV - 1; i++) clk_cycle();
        strobe(4'd3);
        check("coinc_level", 32'(level), 32'd10);
        check("coinc_busy",  32'(busy),  32'h1);
        run(40);
        check("down3_leds",  32'(leds),  32'(10'b0000000111));
        check("down3_level", 32'(level), 32'd3);

        // 5. Mode toggle at level 5.
        strobe(4'd5);
        run(20);
        check("lvl5_level", 32'(level), 32'd5);
        mode = 1'b1;
        clk_cycle();
        check("dot5_leds", 32'(leds), 32'(10'b0000010000));
        mode = 1'b0;
        clk_cycle();
        check("bar5_leds", 32'(leds), 32'(10'b0000011111));

        // 6. Peak behaviour: ramp to 8, then drop toward 2.
        strobe(4'd8);
        for (int i = 0; i < 60 && m_lvl != 8; i++) clk_cycle();
        check("peak_reach8", 32'(level), 32'd8);
        strobe(4'd2);
        for (int i = 0; i < 20 && m_lvl != 7; i++) clk_cycle();
        check("peak_drop7", 32'(level), 32'd7);
        clk_cycle();
        check("peak_bit7_after_drop", 32'(leds[7]), 32'(peak_on));
        run(60);
        check("peak_final_leds",  32'(leds),  32'(10'b0000000011));
        check("peak_final_level", 32'(level), 32'd2);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            value       = $urandom_range(0, 15);
            value_valid = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            clk_cycle();
        end
        value_valid = 1'b0;

        // Make sure something is lit, then assert reset between clock edges.
        mode = 1'b0;
        strobe(4'd9);
        run(12);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_leds",  32'(leds),  32'h0);
        check("async_rst_level", 32'(level), 32'h0);
        check("async_rst_busy",  32'(busy),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run(10);
        check("post_rst_leds", 32'(leds), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
